irq_controller: RTL and testbench
=================================

// Module: irq_controller
// PURPOSE
//  Interrupt controller between SoC peripheral IRQ lines and the CPU interrupt port.
//  - Captures level or edge requests into a pending register and applies a mask.
//  - Picks the highest-priority eligible line (bit 7 highest, bit 0 lowest).
//  - Presents it to the CPU with a req/ack handshake.
//  - Tracks in-service interrupts for nesting and end-of-interrupt (EOI).
// PARAMETERS
//  NUM_IRQ  8                 number of interrupt lines
//  ID_W     $clog2(NUM_IRQ)   width of interrupt id (3 at default)
// PORTS
//  clk         in   1        single clock; all inputs synchronous to it
//  rst_n       in   1        asynchronous, active-low reset
//  irq_src     in   NUM_IRQ  raw request lines, already synchronised to clk
//  edge_sel    in   NUM_IRQ  per line: 1 = rising-edge triggered, 0 = level
//  irq_mask    in   NUM_IRQ  per line: 1 = masked (not eligible)
//  cpu_ack     in   1        CPU accepts presented interrupt (1-cycle pulse)
//  cpu_eoi     in   1        CPU end-of-interrupt (1-cycle pulse)
//  cpu_irq     out  1        interrupt request to CPU (registered)
//  cpu_irq_id  out  ID_W     id of presented interrupt (registered; valid while cpu_irq=1)
//  in_service  out  NUM_IRQ  in-service bitmap (registered)
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - cpu_irq=0, cpu_irq_id=0, in_service=0.
//   - Internal: pending=0, prev_src=0, state=IDLE.
//  Pending capture, per line i:
//   - Edge mode: pending[i] sets when irq_src[i]=1 and prev_src[i]=0. It clears only on ack of id i.
//     If a new edge and the ack fall in the same cycle, set wins.
//   - Level mode: pending[i] <= irq_src[i] every cycle. Ack does not clear it.
//   - Changing edge_sel[i] clears pending[i] on that cycle.
//  Eligibility (combinational):
//   - elig = pending & ~irq_mask.
//   - best = highest set index of elig.
//   - isr_top = highest set index of in_service.
//   - cand = |elig && (in_service==0 || best > isr_top). Equal or lower priority never preempts.
//  FSM (IDLE, PRESENT):
//   - IDLE:    cand -> PRESENT; cpu_irq<=1, cpu_irq_id<=best.
//   - PRESENT: cpu_irq_id is held stable, with no re-arbitration while waiting.
//     - cpu_ack=1 -> in_service[cpu_irq_id]<=1; clear edge pending of that id; cpu_irq<=0; go IDLE.
//     - Else, if elig[cpu_irq_id]=0 (mask set or level dropped) -> cpu_irq<=0; go IDLE. Request withdrawn, no ack owed.
//   - cpu_ack in IDLE is ignored.
//  Latency:
//   - Edge on irq_src sampled at edge N -> pending visible after N -> cpu_irq=1 after edge N+1.
//   - Minimum re-present after ack: 1 IDLE cycle.
//  EOI:
//   - cpu_eoi clears the highest set bit of in_service (pre-cycle value).
//   - EOI with in_service==0 is ignored.
//   - Ack and EOI in the same cycle: clear isr_top, then set the ack id. Both take effect.
//  Mid-operation reset: everything returns to reset values at once; in-flight presentation is dropped.
// STRUCTURE
//  Package irq_ctrl_pkg:
//   - NUM_IRQ, ID_W defaults.
//   - typedef enum logic {IDLE, PRESENT} irq_state_t.
//   - typedef logic [ID_W-1:0] irq_id_t.
//  Sub-module irq_prio_enc (combinational, parameterised NUM_IRQ):
//   - req -> id, valid. Highest index wins.
//   - Instantiated twice: once on elig, once on in_service.
// TESTING
//  1 Reset: rst_n=0 mid-PRESENT -> cpu_irq=0, in_service=0 immediately. No activity after release with irq_src=0.
//  2 Edge: edge_sel=8'hFF, pulse irq_src[3] one cycle -> cpu_irq=1, id=3 two cycles later.
//    Then ack -> in_service=8'h08, cpu_irq=0.
//  3 Priority: pending 8'h24, no mask -> id=5. After ack+EOI -> id=2 presented.
//  4 Nesting: in_service=8'h08. Raise irq 2 -> no cpu_irq. Raise irq 6 -> id=6.
//    Ack -> in_service=8'h48. EOI -> 8'h08.
//  5 Withdraw: level irq 4 presented, then irq_mask[4]=1 before ack -> cpu_irq drops next cycle, in_service unchanged.
//  6 Same-cycle ack+EOI: in_service=8'h02, present id 7, assert both -> in_service=8'h80.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared parameters and types for the interrupt controller slice.
package irq_ctrl_pkg;

   localparam int NUM_IRQ = 8;
   localparam int ID_W    = $clog2(NUM_IRQ);

   typedef enum logic {IDLE, PRESENT} irq_state_t;

   typedef logic [ID_W-1:0] irq_id_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Priority encoder: reports the highest set request index and whether any bit is set.
module irq_prio_enc #(
   parameter int NUM_IRQ = 8,
   parameter int ID_W    = $clog2(NUM_IRQ)
) (
   input  logic [NUM_IRQ-1:0] req,
   output logic [ID_W-1:0]    id,
   output logic               valid
);

   // Ascending scan so the last (highest) set bit overwrites lower ones.
   always_comb begin
      id    = '0;
      valid = 1'b0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (req[i]) begin
            id    = ID_W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: pending capture, masking, priority arbitration,
// CPU req/ack presentation and in-service tracking with EOI.
module irq_controller
   import irq_ctrl_pkg::*;
#(
   parameter int NUM_IRQ = irq_ctrl_pkg::NUM_IRQ,
   parameter int ID_W    = $clog2(NUM_IRQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_IRQ-1:0] irq_src,
   input  logic [NUM_IRQ-1:0] edge_sel,
   input  logic [NUM_IRQ-1:0] irq_mask,
   input  logic               cpu_ack,
   input  logic               cpu_eoi,
   output logic               cpu_irq,
   output logic [ID_W-1:0]    cpu_irq_id,
   output logic [NUM_IRQ-1:0] in_service
);

   irq_state_t         state;
   logic [NUM_IRQ-1:0] pending;
   logic [NUM_IRQ-1:0] pending_nxt;
   logic [NUM_IRQ-1:0] prev_src;
   logic [NUM_IRQ-1:0] prev_sel;
   logic [NUM_IRQ-1:0] elig;
   logic [NUM_IRQ-1:0] ack_vec;
   logic [NUM_IRQ-1:0] eoi_vec;
   logic [ID_W-1:0]    best;
   logic [ID_W-1:0]    isr_top;
   logic               elig_valid;
   logic               isr_valid;
   logic               ack_fire;
   logic               cand;

   assign elig     = pending & ~irq_mask;
   assign ack_fire = (state == PRESENT) && cpu_ack;
   assign cand     = elig_valid && (!isr_valid || (best > isr_top));

   irq_prio_enc #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_elig_enc (
      .req   (elig),
      .id    (best),
      .valid (elig_valid)
   );

   irq_prio_enc #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_isr_enc (
      .req   (in_service),
      .id    (isr_top),
      .valid (isr_valid)
   );

   // Edge lines: a new rising edge beats a same-cycle ack; a mode change always clears.
   always_comb begin
      ack_vec = '0;
      eoi_vec = '0;
      if (ack_fire) ack_vec[cpu_irq_id] = 1'b1;
      if (cpu_eoi && isr_valid) eoi_vec[isr_top] = 1'b1;
      pending_nxt = ((edge_sel & ((irq_src & ~prev_src) | (pending & ~ack_vec)))
                    | (~edge_sel & irq_src))
                    & ~(edge_sel ^ prev_sel);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending  <= '0;
         prev_src <= '0;
         prev_sel <= '0;
      end else begin
         pending  <= pending_nxt;
         prev_src <= irq_src;
         prev_sel <= edge_sel;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cpu_irq    <= 1'b0;
         cpu_irq_id <= '0;
         in_service <= '0;
      end else begin
         in_service <= (in_service & ~eoi_vec) | ack_vec;
         case (state)
            IDLE: begin
               if (cand) begin
                  state      <= PRESENT;
                  cpu_irq    <= 1'b1;
                  cpu_irq_id <= best;
               end
            end
            PRESENT: begin
               // The presented id stays frozen; only ack or withdrawal ends it.
               if (cpu_ack || !elig[cpu_irq_id]) begin
                  state   <= IDLE;
                  cpu_irq <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               cpu_irq <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_irq_controller.sv
// Scenario bench for irq_controller with a queue of expected presented ids.
module tb_irq_controller;

   logic       clk;
   logic       rst_n;
   logic [7:0] irq_src;
   logic [7:0] edge_sel;
   logic [7:0] irq_mask;
   logic       cpu_ack;
   logic       cpu_eoi;
   logic       cpu_irq;
   logic [2:0] cpu_irq_id;
   logic [7:0] in_service;

   int         errors = 0;
   int         checks = 0;
   logic [2:0] exp_q[$];

   irq_controller dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .irq_src    (irq_src),
      .edge_sel   (edge_sel),
      .irq_mask   (irq_mask),
      .cpu_ack    (cpu_ack),
      .cpu_eoi    (cpu_eoi),
      .cpu_irq    (cpu_irq),
      .cpu_irq_id (cpu_irq_id),
      .in_service (in_service)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      irq_src  = '0;
      edge_sel = 8'hFF;
      irq_mask = '0;
      cpu_ack  = 1'b0;
      cpu_eoi  = 1'b0;
      exp_q.delete();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      tick();
   endtask

   task automatic pulse_src(input logic [7:0] lines);
      irq_src = irq_src | lines;
      tick();
      irq_src = irq_src & ~lines;
   endtask

   task automatic do_ack();
      cpu_ack = 1'b1;
      tick();
      cpu_ack = 1'b0;
   endtask

   task automatic do_eoi();
      cpu_eoi = 1'b1;
      tick();
      cpu_eoi = 1'b0;
   endtask

   task automatic wait_irq(input int budget, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (cpu_irq) begin
            ok = 1'b1;
            return;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      logic       ok;
      logic [7:0] seen;
      do_reset();
      checks++;
      if (cpu_irq !== 1'b0 || cpu_irq_id !== 3'd0 || in_service !== 8'h00) begin
         errors++;
         $display("[TB] FAIL reset_values: irq=%b id=%0d isr=%h, want 0/0/00", cpu_irq, cpu_irq_id, in_service);
      end
      do_ack();
      checks++;
      if (in_service !== 8'h00) begin
         errors++;
         $display("[TB] FAIL ack_in_idle: isr=%h, want 00", in_service);
      end
      pulse_src(8'h08);
      exp_q.push_back(3'd3);
      wait_irq(10, ok);
      void'(exp_q.pop_front());
      do_ack();
      pulse_src(8'h40);
      exp_q.push_back(3'd6);
      wait_irq(10, ok);
      void'(exp_q.pop_front());
      checks++;
      if (!ok || in_service !== 8'h08) begin
         errors++;
         $display("[TB] FAIL reset_setup: ok=%b isr=%h, want 1/08", ok, in_service);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (cpu_irq !== 1'b0 || in_service !== 8'h00) begin
         errors++;
         $display("[TB] FAIL reset_midpresent: irq=%b isr=%h, want 0/00", cpu_irq, in_service);
      end
      tick();
      rst_n = 1'b1;
      seen = '0;
      for (int i = 0; i < 6; i++) begin
         tick();
         seen = seen | {7'd0, cpu_irq} | in_service;
      end
      checks++;
      if (seen !== 8'h00) begin
         errors++;
         $display("[TB] FAIL reset_quiet: activity=%h, want 00", seen);
      end
   endtask

   task automatic test_edge();
      logic [2:0] exp;
      do_reset();
      irq_src[3] = 1'b1;
      exp_q.push_back(3'd3);
      tick();
      irq_src[3] = 1'b0;
      checks++;
      if (cpu_irq !== 1'b0) begin
         errors++;
         $display("[TB] FAIL edge_early: irq=%b, want 0", cpu_irq);
      end
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (cpu_irq !== 1'b1 || cpu_irq_id !== exp) begin
         errors++;
         $display("[TB] FAIL edge_latency: irq=%b id=%0d, want 1/%0d", cpu_irq, cpu_irq_id, exp);
      end
      do_ack();
      checks++;
      if (in_service !== 8'h08 || cpu_irq !== 1'b0) begin
         errors++;
         $display("[TB] FAIL edge_ack: isr=%h irq=%b, want 08/0", in_service, cpu_irq);
      end
   endtask

   task automatic test_priority();
      logic       ok;
      logic [2:0] exp;
      do_reset();
      pulse_src(8'h24);
      exp_q.push_back(3'd5);
      exp_q.push_back(3'd2);
      wait_irq(10, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || cpu_irq_id !== exp) begin
         errors++;
         $display("[TB] FAIL prio_high: ok=%b id=%0d, want 1/%0d", ok, cpu_irq_id, exp);
      end
      do_ack();
      tick();
      tick();
      checks++;
      if (cpu_irq !== 1'b0 || in_service !== 8'h20) begin
         errors++;
         $display("[TB] FAIL prio_blocked: irq=%b isr=%h, want 0/20", cpu_irq, in_service);
      end
      do_eoi();
      checks++;
      if (in_service !== 8'h00) begin
         errors++;
         $display("[TB] FAIL prio_eoi: isr=%h, want 00", in_service);
      end
      wait_irq(10, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || cpu_irq_id !== exp) begin
         errors++;
         $display("[TB] FAIL prio_low: ok=%b id=%0d, want 1/%0d", ok, cpu_irq_id, exp);
      end
   endtask

   task automatic test_nesting();
      logic       ok;
      logic [2:0] exp;
      do_reset();
      pulse_src(8'h08);
      exp_q.push_back(3'd3);
      wait_irq(10, ok);
      void'(exp_q.pop_front());
      do_ack();
      checks++;
      if (in_service !== 8'h08) begin
         errors++;
         $display("[TB] FAIL nest_setup: isr=%h, want 08", in_service);
      end
      pulse_src(8'h04);
      wait_irq(5, ok);
      checks++;
      if (ok) begin
         errors++;
         $display("[TB] FAIL nest_lower: irq=%b id=%0d, want no request", cpu_irq, cpu_irq_id);
      end
      pulse_src(8'h40);
      exp_q.push_back(3'd6);
      wait_irq(10, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || cpu_irq_id !== exp) begin
         errors++;
         $display("[TB] FAIL nest_preempt: ok=%b id=%0d, want 1/%0d", ok, cpu_irq_id, exp);
      end
      do_ack();
      checks++;
      if (in_service !== 8'h48) begin
         errors++;
         $display("[TB] FAIL nest_ack: isr=%h, want 48", in_service);
      end
      do_eoi();
      checks++;
      if (in_service !== 8'h08) begin
         errors++;
         $display("[TB] FAIL nest_eoi: isr=%h, want 08", in_service);
      end
   endtask

   task automatic test_withdraw();
      logic       ok;
      logic [2:0] exp;
      do_reset();
      edge_sel[4] = 1'b0;
      irq_src[4]  = 1'b1;
      exp_q.push_back(3'd4);
      wait_irq(10, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || cpu_irq_id !== exp) begin
         errors++;
         $display("[TB] FAIL withdraw_present: ok=%b id=%0d, want 1/%0d", ok, cpu_irq_id, exp);
      end
      irq_mask[4] = 1'b1;
      tick();
      checks++;
      if (cpu_irq !== 1'b0 || in_service !== 8'h00) begin
         errors++;
         $display("[TB] FAIL withdraw_drop: irq=%b isr=%h, want 0/00", cpu_irq, in_service);
      end
      irq_src  = '0;
      irq_mask = '0;
      edge_sel = 8'hFF;
   endtask

   task automatic test_back_to_back();
      logic       ok;
      logic [2:0] exp;
      do_reset();
      pulse_src(8'h02);
      exp_q.push_back(3'd1);
      wait_irq(10, ok);
      void'(exp_q.pop_front());
      do_ack();
      pulse_src(8'h80);
      exp_q.push_back(3'd7);
      wait_irq(10, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || cpu_irq_id !== exp || in_service !== 8'h02) begin
         errors++;
         $display("[TB] FAIL b2b_present: ok=%b id=%0d isr=%h, want 1/%0d/02", ok, cpu_irq_id, in_service, exp);
      end
      cpu_ack = 1'b1;
      cpu_eoi = 1'b1;
      tick();
      cpu_ack = 1'b0;
      cpu_eoi = 1'b0;
      checks++;
      if (in_service !== 8'h80 || cpu_irq !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_ack_eoi: isr=%h irq=%b, want 80/0", in_service, cpu_irq);
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      irq_src  = '0;
      edge_sel = 8'hFF;
      irq_mask = '0;
      cpu_ack  = 1'b0;
      cpu_eoi  = 1'b0;
      test_reset();
      test_edge();
      test_priority();
      test_nesting();
      test_withdraw();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
